// File: rtl/fpu_pkg.sv
// Shared FPU definitions: special-case and rounding-mode encodings, QNaN constant,
// default single-precision field widths and the rounding-increment decision.
package fpu_pkg;

  localparam int unsigned EXP_W_DEF = 8;
  localparam int unsigned MAN_W_DEF = 23;

  localparam logic [31:0] QNAN_SP = 32'h7FC00000;

  typedef enum logic [1:0] {
    SPC_NORMAL = 2'b00,
    SPC_ZERO   = 2'b01,
    SPC_INF    = 2'b10,
    SPC_NAN    = 2'b11
  } special_e;

  typedef enum logic [1:0] {
    RND_RNE = 2'b00,
    RND_RTZ = 2'b01,
    RND_RUP = 2'b10,
    RND_RDN = 2'b11
  } rnd_mode_e;

  // Whether the truncated mantissa must be bumped by one ulp
  function automatic logic round_inc(input logic [1:0] mode, input logic sign,
                                     input logic g, input logic s, input logic lsb);
    logic inc;
    inc = 1'b0;
    case (mode)
      RND_RNE: inc = g & (s | lsb);
      RND_RTZ: inc = 1'b0;
      RND_RUP: inc = (g | s) & ~sign;
      RND_RDN: inc = (g | s) & sign;
      default: inc = 1'b0;
    endcase
    return inc;
  endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Synchronous result FIFO shared by the FPU result paths; a push into a full
// FIFO without a same-cycle pop is dropped and latches a sticky overflow flag.
module fpu_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_din,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_dout,
  output logic                       o_valid,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_valid;
  logic             r_overflow;

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [CW-1:0]    w_count_nx;

  // A pop frees the head slot, so a push into a full FIFO still lands that cycle
  assign w_full     = (r_count == CW'(DEPTH));
  assign w_pop      = i_pop & r_valid;
  assign w_push     = i_push & (~w_full | w_pop);
  assign w_drop     = i_push & w_full & ~w_pop;
  assign w_count_nx = r_count + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_valid    <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count    <= w_count_nx;
      r_valid    <= (w_count_nx != '0);
      r_overflow <= r_overflow | w_drop;
    end
  end

  assign o_dout     = r_mem[r_rd_ptr];
  assign o_valid    = r_valid;
  assign o_count    = r_count;
  assign o_overflow = r_overflow;

endmodule

// File: rtl/sqrt_round_pack.sv
// Square-root post-processing: rounds the fixed-point root to IEEE format, packs
// it with special cases and queues it in an output FIFO that absorbs backpressure.
module sqrt_round_pack
  import fpu_pkg::*;
#(
  parameter int unsigned EXP_W  = EXP_W_DEF,
  parameter int unsigned MAN_W  = MAN_W_DEF,
  parameter int unsigned ROOT_W = MAN_W + 3,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [ROOT_W-1:0]          root,
  input  logic                       sticky,
  input  logic                       sign_in,
  input  logic [EXP_W-1:0]           exp_in,
  input  logic [1:0]                 special,
  input  logic                       invalid_in,
  input  logic [1:0]                 rnd_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       result,
  output logic                       inexact,
  output logic                       invalid,
  output logic                       overflow,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
  localparam int unsigned ENT_W = RES_W + 2;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  localparam logic [RES_W-1:0] QNAN = (RES_W == 32) ? RES_W'(QNAN_SP)
                                    : {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
  localparam logic [RES_W-1:0] PINF = {1'b0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};

  logic [MAN_W-1:0]  w_m;
  logic              w_g;
  logic              w_s;
  logic              w_inc;
  logic [MAN_W:0]    w_sum;
  logic [EXP_W:0]    w_exp;
  logic              w_exp_ovf;
  logic [RES_W-1:0]  w_res;
  logic              w_inx;

  logic              r_s1_valid;
  logic [ENT_W-1:0]  r_s1_data;

  logic [ENT_W-1:0]  w_head;
  logic [CNT_W-1:0]  w_count;

  // Normal results are always positive, so directed modes see sign 0
  assign w_m       = root[ROOT_W-2:2];
  assign w_g       = root[1];
  assign w_s       = root[0] | sticky;
  assign w_inc     = round_inc(rnd_mode, 1'b0, w_g, w_s, w_m[0]);
  assign w_sum     = {1'b0, w_m} + (MAN_W+1)'(w_inc);
  assign w_exp     = {1'b0, exp_in} + (EXP_W+1)'(w_sum[MAN_W]);
  assign w_exp_ovf = (w_exp >= (EXP_W+1)'({EXP_W{1'b1}}));

  always_comb begin
    w_res = '0;
    w_inx = 1'b0;
    case (special)
      SPC_ZERO: w_res = {sign_in, {(RES_W-1){1'b0}}};
      SPC_INF:  w_res = PINF;
      SPC_NAN:  w_res = QNAN;
      default: begin
        if (w_exp_ovf) begin
          w_res = PINF;
          w_inx = 1'b1;
        end else begin
          w_res = {1'b0, w_exp[EXP_W-1:0], w_sum[MAN_W-1:0]};
          w_inx = w_g | w_s;
        end
      end
    endcase
  end

  // Stage 1: capture the rounded entry on the core's done pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_s1_valid <= 1'b0;
      r_s1_data  <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) r_s1_data <= {w_res, w_inx, invalid_in};
    end
  end

  fpu_sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_s1_valid),
    .i_din      (r_s1_data),
    .i_pop      (out_ready),
    .o_dout     (w_head),
    .o_valid    (out_valid),
    .o_count    (w_count),
    .o_overflow (overflow)
  );

  assign result  = w_head[ENT_W-1:2];
  assign inexact = w_head[1];
  assign invalid = w_head[0];
  assign count   = w_count;

endmodule

// File: doc/sqrt_round_pack.md
# sqrt_round_pack

Post-processing stage for the FPU square-root path. It takes the normalized fixed-point root, sticky bit and done pulse from the fixed-point square-root core, together with the sign, exponent and special-case code the front end carries alongside. It rounds the root to IEEE-754 single precision, packs the result and queues it in an output FIFO with a valid/ready handshake. The core cannot stall, so this block absorbs backpressure and reports overflow.

## Interface
- `EXP_W`, default 8, exponent width.
- `MAN_W`, default 23, stored mantissa width.
- `ROOT_W`, default `MAN_W+3`, root width: hidden bit, mantissa, guard, round.
- `DEPTH`, default 4, output FIFO entries (power of two, ≥2).
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-low.
- `in_valid`  in  1  root-core done pulse; one result per asserted cycle.
- `root`  in  `ROOT_W`  normalized root, bit `ROOT_W-1` = 1 for normal operands.
- `sticky`  in  1  remainder non-zero.
- `sign_in`  in  1  operand sign; meaningful only for ±0.
- `exp_in`  in  `EXP_W`  biased result exponent, computed upstream.
- `special`  in  2  00 normal, 01 zero, 10 +inf, 11 NaN.
- `invalid_in`  in  1  negative non-zero operand, or sNaN.
- `rnd_mode`  in  2  00 RNE, 01 RTZ, 10 RUP (+inf), 11 RDN (−inf).
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  consumer accepts the head entry.
- `result`  out  `1+EXP_W+MAN_W`  packed IEEE value at the FIFO head.
- `inexact`  out  1  head entry was rounded.
- `invalid`  out  1  head entry invalid.
- `overflow`  out  1  sticky: a result was dropped; cleared only by reset.
- `count`  out  `$clog2(DEPTH)+1`  FIFO occupancy.

## Operation
- Field split:
  - `m = root[ROOT_W-2:2]`
  - `G = root[1]`
  - `S = root[0] | sticky`
  - `lsb = m[0]`
- Increment by rounding mode:
  - RNE: `G & (S | lsb)`
  - RTZ: 0
  - RUP: `(G | S) & ~sign`
  - RDN: `(G | S) & sign`
  - Sign is 0 for normal results.
- Mantissa carry: `m` all ones plus increment gives `m = 0`, `exp = exp_in + 1`.
- If the exponent reaches all ones, the result is +inf and `inexact` = 1. This is unreachable for single-precision sqrt, but it must still be implemented.
- Normal: `result = {0, exp, m}`, `inexact = G | S`.
- Special codes, all with `inexact` = 0:
  - zero: `{sign_in, 0, 0}`
  - +inf: `{0, all-ones, 0}`
  - NaN: QNaN `{0, all-ones, 1, 0…}`
- `invalid` = `invalid_in`. The `root`, `sticky` and `rnd_mode` inputs are ignored for special codes.
- FIFO behaviour:
  - Push on a stage-1 valid.
  - Pop on `out_valid & out_ready`.
  - A push while full with no pop in the same cycle drops the new entry and sets `overflow`.
  - A push while full with a pop in the same cycle succeeds; `count` is unchanged.
  - A pop while empty is ignored.
  - Pointers wrap modulo `DEPTH`.
  - Order is strict FIFO.

## Timing
- Stage 1: inputs registered on the edge ending the cycle in which `in_valid` = 1, so rounding is done in one cycle.
- Stage 2: FIFO write on the following edge.
- Latency with an empty FIFO: `in_valid` in cycle N gives `out_valid` = 1 in cycle N+2.
- Throughput is one result per cycle; inputs may arrive every cycle.
- `result`, `inexact` and `invalid` hold stable while `out_valid & ~out_ready`.
- Reset values:
  - `out_valid`, `result`, `inexact`, `invalid`, `overflow`, `count` all 0.
  - Stage-1 register and FIFO pointers cleared.
- Reset mid-operation discards all queued and in-flight results immediately. There is no output activity until a new `in_valid` arrives.

## Structure
- Shared package `fpu_pkg`:
  - special-code encodings
  - rounding-mode encodings
  - QNaN constant `32'h7FC00000`
  - default `EXP_W`/`MAN_W`
- Sub-module `fpu_sync_fifo`: parameterized width and depth, with push, pop, full, empty, count and the drop-on-full policy. It is reusable by the other FPU result paths.
- The top level holds the rounding logic and the stage-1 register.

## Test plan
- Exact result: `root=26'h3000000`, `sticky=0`, `exp_in=127`, RNE → `result=32'h3FC00000`, `inexact=0`, `out_valid` in cycle N+2.
- Tie to even: `root=26'h2000002`, `sticky=0`, RNE → `32'h3F800000`, `inexact=1`. The same input with `sticky=1` → `32'h3F800001`.
- Mantissa carry: `root=26'h3FFFFFE`, `exp_in=127`, RNE → `32'h40000000`, `inexact=1`. The same input with RTZ → `32'h3FFFFFFF`.
- Specials:
  - `special=11`, `invalid_in=1` → `32'h7FC00000`, `invalid=1`.
  - `special=01`, `sign_in=1` → `32'h80000000`.
  - `special=10` → `32'h7F800000`.
- Backpressure: `out_ready=0`, 5 back-to-back results with `DEPTH=4` → `count=4`, `overflow=1`, fifth result lost. Raise `out_ready` → first four drain in order, one per cycle.
- Reset while holding 3 entries with a push in flight: `rst` low → outputs 0 immediately. After release, `out_valid` stays 0 until a new `in_valid`.
